// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable divider, x/y raster counters, and
// registered hsync/vsync/video_on aligned with the counters they describe.
// Optional feature: define VGA_SYNC_FRAME_TICK_EN to generate frame_tick.
// Without it, frame_tick is tied to 0 and no logic is built for it.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Raster totals must fit the 10-bit counters.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 1024");
  end

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_d;
  logic [9:0]       x_d;
  logic [9:0]       y_d;

  // Next-state divider and raster counters; outputs are registered from these.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d = '0;
    end
    tick_d = (div_d == DIV_W'(CLK_DIV - 1));

    x_d = pixel_x;
    y_d = pixel_y;
    if (p_tick) begin
      if (pixel_x == 10'(H_TOTAL - 1)) begin
        x_d = '0;
        if (pixel_y == 10'(V_TOTAL - 1)) begin
          y_d = '0;
        end else begin
          y_d = pixel_y + 10'd1;
        end
      end else begin
        x_d = pixel_x + 10'd1;
      end
    end
  end

  // Divider, counters and sync/blank outputs, all updated on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q    <= '0;
      p_tick   <= (CLK_DIV == 1);
      pixel_x  <= '0;
      pixel_y  <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b1;
    end else begin
      div_q    <= div_d;
      p_tick   <= tick_d;
      pixel_x  <= x_d;
      pixel_y  <= y_d;
      hsync    <= !((x_d >= 10'(HS_START)) && (x_d <= 10'(HS_END)));
      vsync    <= !((y_d >= 10'(VS_START)) && (y_d <= 10'(VS_END)));
      video_on <= (x_d < 10'(H_DISPLAY)) && (y_d < 10'(V_DISPLAY));
    end
  end

`ifdef VGA_SYNC_FRAME_TICK_EN
  // One-clk pulse on the pixel tick that enters vertical blanking at (0, V_DISPLAY).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick_d && (x_d == 10'd0) && (y_d == 10'(V_DISPLAY));
    end
  end
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a full-size instance (CLK_DIV=4, 640x480
// timing) for divider phase and line timing, and a miniature-timing instance
// (CLK_DIV=2, 15x11 raster) for whole-frame, frame_tick and mid-frame reset.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vid;
    logic       ft;
  } exp_t;

`ifdef VGA_SYNC_FRAME_TICK_EN
  localparam int FT_EN = 1;
`else
  localparam int FT_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_d, rstn_s;
  logic       p_tick_d, video_on_d, hsync_d, vsync_d, frame_tick_d;
  logic [9:0] pixel_x_d, pixel_y_d;
  logic       p_tick_s, video_on_s, hsync_s, vsync_s, frame_tick_s;
  logic [9:0] pixel_x_s, pixel_y_s;

  vga_sync_gen #(.CLK_DIV(4)) u_d (
    .clk(clk), .rstn(rstn_d), .p_tick(p_tick_d), .pixel_x(pixel_x_d),
    .pixel_y(pixel_y_d), .video_on(video_on_d), .hsync(hsync_d),
    .vsync(vsync_d), .frame_tick(frame_tick_d)
  );

  // Miniature raster: H 8/2/3/2 (total 15, hsync low x=10..12),
  // V 6/1/2/2 (total 11, vsync low y=7..8), 48 visible pixels per frame.
  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) u_s (
    .clk(clk), .rstn(rstn_s), .p_tick(p_tick_s), .pixel_x(pixel_x_s),
    .pixel_y(pixel_y_s), .video_on(video_on_s), .hsync(hsync_s),
    .vsync(vsync_s), .frame_tick(frame_tick_s)
  );

  int errors = 0;
  int checks = 0;

  exp_t q_d[$];
  exp_t q_s[$];

  int cyc_d = 0;
  int hs_low_line0 = 0;
  int s_ticks = 0;
  int vis_cnt = 0;
  int vs_low = 0;
  int ft_clks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int pk(input logic [9:0] x, input logic [9:0] y,
                            input logic hs, input logic vs,
                            input logic vid, input logic ft);
    exp_t e;
    e = '{x: x, y: y, hs: hs, vs: vs, vid: vid, ft: ft};
    return int'(e);
  endfunction

  // Expected tick stream for the miniature raster, starting at (0,0).
  task automatic push_s(input int frames);
    exp_t e;
    for (int f = 0; f < frames; f++)
      for (int y = 0; y < 11; y++)
        for (int x = 0; x < 15; x++) begin
          e.x   = 10'(x);
          e.y   = 10'(y);
          e.hs  = !(x >= 10 && x <= 12);
          e.vs  = !(y >= 7 && y <= 8);
          e.vid = (x < 8) && (y < 6);
          e.ft  = (FT_EN == 1) && (x == 0) && (y == 6);
          q_s.push_back(e);
        end
  endtask

  // Expected tick stream for the full-size raster over the first n ticks.
  task automatic push_d(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.x   = 10'(i % 800);
      e.y   = 10'(i / 800);
      e.hs  = !((i % 800) >= 656 && (i % 800) <= 751);
      e.vs  = 1'b1;
      e.vid = (i % 800) < 640;
      e.ft  = 1'b0;
      q_d.push_back(e);
    end
  endtask

  // Monitor for the full-size instance: divider phase and tick-by-tick compare.
  always @(negedge clk) begin : mon_d
    exp_t e;
    if (rstn_d) begin
      cyc_d++;
      if (cyc_d <= 24) check("p_tick_phase_d", int'(p_tick_d), int'(cyc_d % 4 == 0));
      if (p_tick_d && q_d.size() > 0) begin
        e = q_d.pop_front();
        check("pixel_d", pk(pixel_x_d, pixel_y_d, hsync_d, vsync_d, video_on_d, frame_tick_d), int'(e));
        if (pixel_y_d == 10'd0 && !hsync_d) hs_low_line0++;
      end
    end
  end

  // Monitor for the miniature instance: tick compare plus frame aggregates.
  always @(negedge clk) begin : mon_s
    exp_t e;
    if (rstn_s) begin
      if (frame_tick_s) ft_clks++;
      if (p_tick_s) begin
        s_ticks++;
        if (video_on_s) vis_cnt++;
        if (!vsync_s) vs_low++;
        if (q_s.size() > 0) begin
          e = q_s.pop_front();
          check("pixel_s", pk(pixel_x_s, pixel_y_s, hsync_s, vsync_s, video_on_s, frame_tick_s), int'(e));
        end
      end
    end
  end

  initial begin
    bit found;
    rstn_d = 1'b0;
    rstn_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_d", pk(pixel_x_d, pixel_y_d, hsync_d, vsync_d, video_on_d, frame_tick_d),
          pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    check("reset_ptick_d", int'(p_tick_d), 0);
    check("reset_state_s", pk(pixel_x_s, pixel_y_s, hsync_s, vsync_s, video_on_s, frame_tick_s),
          pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0));

    // Full-size instance: two lines plus 100 pixels.
    @(posedge clk);
    #2;
    push_d(1700);
    rstn_d = 1'b1;
    repeat (1700 * 4 + 8) @(posedge clk);
    #2;
    check("drain_d", q_d.size(), 0);
    check("hsync_low_ticks_line0", hs_low_line0, 96);

    // Miniature instance: two full frames.
    push_s(2);
    rstn_s = 1'b1;
    repeat (660) @(posedge clk);
    #2;
    check("drain_s", q_s.size(), 0);
    check("ticks_2frames", s_ticks, 330);
    check("visible_2frames", vis_cnt, 96);
    check("vsync_low_2frames", vs_low, 60);
    check("frame_tick_clks", ft_clks, 2 * FT_EN);

    // Run into the sync region and reset asynchronously between edges.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #2;
      if (pixel_x_s == 10'd11 && pixel_y_s == 10'd7) found = 1'b1;
    end
    check("reach_mid_frame", int'(found), 1);
    check("in_sync_before_reset", int'({hsync_s, vsync_s}), 0);
    #1;
    rstn_s = 1'b0;
    #1;
    check("async_reset_s", pk(pixel_x_s, pixel_y_s, hsync_s, vsync_s, video_on_s, frame_tick_s),
          pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    check("async_reset_ptick_s", int'(p_tick_s), 0);
    repeat (3) @(posedge clk);
    #2;
    q_s.delete();
    s_ticks = 0;
    vis_cnt = 0;
    vs_low  = 0;
    ft_clks = 0;
    push_s(1);
    rstn_s = 1'b1;
    repeat (330) @(posedge clk);
    #2;
    check("drain_after_reset", q_s.size(), 0);
    check("ticks_1frame", s_ticks, 165);
    check("visible_1frame", vis_cnt, 48);
    check("vsync_low_1frame", vs_low, 30);
    check("frame_tick_after_reset", ft_clks, FT_EN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
